// File: rtl/mul_ctrl_if.sv
// Handshake and datapath-control bundle between the multiplier controller
// and its host/datapath.
interface mul_ctrl_if;
    logic start;
    logic abort;
    logic eqz;
    logic ldA;
    logic ldB;
    logic clrP;
    logic ldP;
    logic decB;
    logic ready;
    logic done;
    logic err;

    modport master (
        output start, abort, eqz,
        input  ldA, ldB, clrP, ldP, decB, ready, done, err
    );

    modport slave (
        input  start, abort, eqz,
        output ldA, ldB, clrP, ldP, decB, ready, done, err
    );
endinterface

// File: rtl/mul_ctrl.sv
// Control FSM for a repeated-addition multiplier: loads A and the B down
// counter, accumulates A until the counter hits zero, with watchdog and abort.
module mul_ctrl #(
    parameter int          ITER_W   = 16,
    parameter int unsigned MAX_ITER = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    mul_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        LDA,
        LDB,
        CHK,
        DONE,
        ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;

    logic ld_a, ld_b, clr_p, ld_p, dec_b, ready, done, err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        clr_p   = 1'b0;
        ld_p    = 1'b0;
        dec_b   = 1'b0;
        ready   = 1'b0;
        done    = 1'b0;
        err     = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.start && !bus.abort) state_d = LDA;
            end
            LDA: begin
                ld_a    = 1'b1;
                state_d = LDB;
            end
            LDB: begin
                ld_b    = 1'b1;
                clr_p   = 1'b1;
                iter_d  = '0;
                state_d = CHK;
            end
            CHK: begin
                if (bus.eqz) begin
                    state_d = DONE;
                end else if (iter_q == ITER_W'(MAX_ITER)) begin
                    state_d = ERR;
                end else begin
                    ld_p   = 1'b1;
                    dec_b  = 1'b1;
                    iter_d = iter_q + ITER_W'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                err     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything outside IDLE and suppresses every strobe.
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            iter_d  = '0;
            ld_a    = 1'b0;
            ld_b    = 1'b0;
            clr_p   = 1'b0;
            ld_p    = 1'b0;
            dec_b   = 1'b0;
            done    = 1'b0;
            err     = 1'b0;
        end
    end

    assign bus.ldA   = ld_a;
    assign bus.ldB   = ld_b;
    assign bus.clrP  = clr_p;
    assign bus.ldP   = ld_p;
    assign bus.decB  = dec_b;
    assign bus.ready = ready;
    assign bus.done  = done;
    assign bus.err   = err;

endmodule

// File: tb/tb_mul_ctrl.sv
// Scoreboard bench for mul_ctrl: behavioural A register, 16-bit down counter
// and accumulator around a default instance and a MAX_ITER=4 instance.
module tb_mul_ctrl;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   decb1;

    typedef struct {
        bit is_err;
        int cyc;
        int prod;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    mul_ctrl_if if0 ();
    mul_ctrl_if if1 ();

    mul_ctrl u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    mul_ctrl #(.ITER_W(16), .MAX_ITER(4)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapath for each instance; one shared bus carries A or B.
    logic [15:0] a_in0, b_in0, a_reg0, cnt0;
    logic [15:0] a_in1, b_in1, a_reg1, cnt1;
    logic [31:0] prod0, prod1;

    assign if0.eqz = (cnt0 == 16'd0);
    assign if1.eqz = (cnt1 == 16'd0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg0 <= '0; cnt0 <= '0; prod0 <= '0;
            a_reg1 <= '0; cnt1 <= '0; prod1 <= '0;
        end else begin
            if (if0.ldA) a_reg0 <= a_in0;
            if (if0.ldB) cnt0 <= b_in0;
            else if (if0.decB) cnt0 <= cnt0 - 16'd1;
            if (if0.clrP) prod0 <= '0;
            else if (if0.ldP) prod0 <= prod0 + {16'd0, a_reg0};
            if (if1.ldA) a_reg1 <= a_in1;
            if (if1.ldB) cnt1 <= b_in1;
            else if (if1.decB) cnt1 <= cnt1 - 16'd1;
            if (if1.clrP) prod1 <= '0;
            else if (if1.ldP) prod1 <= prod1 + {16'd0, a_reg1};
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Output vector order: {ready, ldA, ldB, clrP, ldP, decB, done, err}
    function automatic logic [7:0] vec(input int inst);
        if (inst == 0)
            return {if0.ready, if0.ldA, if0.ldB, if0.clrP, if0.ldP, if0.decB, if0.done, if0.err};
        else
            return {if1.ready, if1.ldA, if1.ldB, if1.clrP, if1.ldP, if1.decB, if1.done, if1.err};
    endfunction

    // Monitor: pops an expectation whenever done or err appears.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (if0.done || if0.err) begin
                if (sb0.size() == 0) begin
                    checkOutput("u0_unexpected_done_err", 1, 0);
                end else begin
                    e = sb0.pop_front();
                    checkOutput("u0_kind_err", int'(if0.err), int'(e.is_err));
                    checkOutput("u0_event_cycle", cyc, e.cyc);
                    checkOutput("u0_product", int'(prod0), e.prod);
                end
            end
            if (if1.done || if1.err) begin
                if (sb1.size() == 0) begin
                    checkOutput("u1_unexpected_done_err", 1, 0);
                end else begin
                    e = sb1.pop_front();
                    checkOutput("u1_kind_err", int'(if1.err), int'(e.is_err));
                    checkOutput("u1_event_cycle", cyc, e.cyc);
                    checkOutput("u1_product", int'(prod1), e.prod);
                end
            end
            if (if1.decB) decb1++;
        end
    end

    // Called on a negedge: raises start, so the current cycle becomes cycle 0.
    task automatic applyStimulus(input int inst, input int a, input int b, output int t0);
        t0 = cyc;
        if (inst == 0) begin
            a_in0 = 16'(a); b_in0 = 16'(b); if0.start = 1'b1;
        end else begin
            a_in1 = 16'(a); b_in1 = 16'(b); if1.start = 1'b1;
        end
    endtask

    task automatic pushExp(input int inst, input bit is_err, input int c, input int p);
        exp_t e;
        e.is_err = is_err; e.cyc = c; e.prod = p;
        if (inst == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endtask

    // Checks n per-cycle output vectors from cycle 0; start drops at cycle drop_at.
    task automatic runSeq(input int inst, input string tag, input logic [127:0] seq,
                          input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) begin
                if (inst == 0) if0.start = 1'b0;
                else if1.start = 1'b0;
            end
            checkOutput($sformatf("%s_c%0d", tag, i), int'(vec(inst)), int'(seq[127-8*i -: 8]));
            if (i < n - 1) @(negedge clk);
        end
    endtask

    initial begin
        int t0;
        cyc = 0; n_checks = 0; n_pass = 0; decb1 = 0;
        rst_n = 1'b0;
        if0.start = 1'b0; if0.abort = 1'b0;
        if1.start = 1'b0; if1.abort = 1'b0;
        a_in0 = '0; b_in0 = '0; a_in1 = '0; b_in1 = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_u0", int'(vec(0)), 8'h80);
        checkOutput("reset_u1", int'(vec(1)), 8'h80);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of a long multiply
        applyStimulus(0, 5, 100, t0);
        @(negedge clk);
        if0.start = 1'b0;
        repeat (19) @(negedge clk);
        checkOutput("t1_in_chk", int'(vec(0)), 8'h0C);
        rst_n = 1'b0;
        #1;
        checkOutput("t1_after_reset", int'(vec(0)), 8'h80);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 7 * 3
        applyStimulus(0, 7, 3, t0);
        pushExp(0, 1'b0, t0 + 7, 21);
        runSeq(0, "t2", {8'h80, 8'h40, 8'h30, 8'h0C, 8'h0C, 8'h0C, 8'h00, 8'h02, 8'h80, 56'h0}, 9, 1);

        // 9 * 0: no accumulate at all
        applyStimulus(0, 9, 0, t0);
        pushExp(0, 1'b0, t0 + 4, 0);
        runSeq(0, "t3", {8'h80, 8'h40, 8'h30, 8'h00, 8'h02, 8'h80, 80'h0}, 6, 1);

        // Abort mid-CHK, then a clean 3 * 2
        applyStimulus(0, 3, 50, t0);
        @(negedge clk);
        if0.start = 1'b0;
        repeat (9) @(negedge clk);
        if0.abort = 1'b1;
        #1;
        checkOutput("t5_abort_cycle", int'(vec(0)), 8'h00);
        @(negedge clk);
        if0.abort = 1'b0;
        checkOutput("t5_idle_after_abort", int'(vec(0)), 8'h80);
        applyStimulus(0, 3, 2, t0);
        pushExp(0, 1'b0, t0 + 6, 6);
        runSeq(0, "t5b", {8'h80, 8'h40, 8'h30, 8'h0C, 8'h0C, 8'h00, 8'h02, 8'h80, 64'h0}, 8, 1);

        // start held high across a whole 4 * 2 op and into the following IDLE
        applyStimulus(0, 4, 2, t0);
        pushExp(0, 1'b0, t0 + 6, 8);
        pushExp(0, 1'b0, t0 + 13, 8);
        runSeq(0, "t6", {8'h80, 8'h40, 8'h30, 8'h0C, 8'h0C, 8'h00, 8'h02, 8'h80, 8'h40, 56'h0}, 9, 8);
        repeat (8) @(negedge clk);
        checkOutput("t6_second_op_idle", int'(vec(0)), 8'h80);

        // Watchdog on the MAX_ITER=4 instance: 2 * 10
        applyStimulus(1, 2, 10, t0);
        pushExp(1, 1'b1, t0 + 8, 8);
        runSeq(1, "t4", {8'h80, 8'h40, 8'h30, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h00, 8'h01, 8'h80, 48'h0}, 10, 1);
        repeat (4) @(negedge clk);
        checkOutput("t4_decb_pulses", decb1, 4);

        checkOutput("sb0_drained", sb0.size(), 0);
        checkOutput("sb1_drained", sb1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
